// File: rtl/fp_accum_seq.sv
// Streams IEEE754 operands into an external combinational fp_adder and
// accumulates one running sum per vector, with MAX_LEN forced termination.
module fp_accum_seq #(
  parameter int unsigned ADD_LATENCY = 1,
  parameter int unsigned MAX_LEN     = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int unsigned WW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  typedef enum logic [1:0] {ST_ACCEPT, ST_ADD, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             at_max;

  assign cnt_inc = cnt_q + 1'b1;
  assign at_max  = (cnt_inc == CNT_W'(MAX_LEN));

  // Adder operands come straight from registers; in_data never reaches the adder combinationally.
  assign add_a     = acc_q;
  assign add_b     = op_q;
  assign in_ready  = (state_q == ST_ACCEPT);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_count = out_valid ? cnt_q : '0;
  assign out_ovf   = out_valid & ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACCEPT: begin
        if (in_valid) begin
          op_d    = in_data;
          cnt_d   = cnt_inc;
          last_d  = in_last | at_max;
          ovf_d   = at_max & ~in_last;
          wait_d  = WW'(ADD_LATENCY - 1);
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        if (wait_q == '0) begin
          acc_d   = add_result;
          state_d = last_q ? ST_DONE : ST_ACCEPT;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCEPT;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq: three instances (baseline, MAX_LEN=4, ADD_LATENCY=3)
// driven by a table-based adder model covering the sums used below.
module tb_fp_accum_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv[3], il[3], ordy[3], ir[3], ov[3], ovf[3];
  logic [31:0] id[3], aa[3], ab[3], ar[3], od[3], ocx[3];
  logic [10:0] oc0, oc2;
  logic [2:0]  oc1;

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-computed single-precision sums; zero operand passes the other through bit-exact.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h40400000_40400000: return 32'h40C00000;
      64'h3F800000_BF800000: return 32'h00000000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40000000_3F800000: return 32'h40400000;
      64'h40400000_3F800000: return 32'h40800000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  assign ar[0] = fadd(aa[0], ab[0]);
  assign ar[1] = fadd(aa[1], ab[1]);
  assign ar[2] = fadd(aa[2], ab[2]);
  assign ocx[0] = {21'b0, oc0};
  assign ocx[1] = {29'b0, oc1};
  assign ocx[2] = {21'b0, oc2};

  fp_accum_seq #(.ADD_LATENCY(1), .MAX_LEN(1024), .CNT_W(11)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .in_last(il[0]), .add_a(aa[0]), .add_b(ab[0]), .add_result(ar[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_count(oc0),
    .out_ovf(ovf[0]));

  fp_accum_seq #(.ADD_LATENCY(1), .MAX_LEN(4), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .in_last(il[1]), .add_a(aa[1]), .add_b(ab[1]), .add_result(ar[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_count(oc1),
    .out_ovf(ovf[1]));

  fp_accum_seq #(.ADD_LATENCY(3), .MAX_LEN(1024), .CNT_W(11)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .in_last(il[2]), .add_a(aa[2]), .add_b(ab[2]), .add_result(ar[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_count(oc2),
    .out_ovf(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one element; returns at the negedge following the accepting edge.
  task automatic send(input int d, input logic [31:0] data, input logic last);
    int n;
    id[d] = data;
    il[d] = last;
    iv[d] = 1'b1;
    n = 0;
    while (!ir[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, ir[d]}, 32'd1);
    @(negedge clk);
    iv[d] = 1'b0;
    il[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    int n;
    n = 0;
    while (!ov[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk("out_valid_seen", {31'b0, ov[d]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int unsigned t_a;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; il[k] = 1'b0; id[k] = '0; ordy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready",  {31'b0, ir[k]},  32'd1);
      chk("rst_out_valid", {31'b0, ov[k]},  32'd0);
      chk("rst_out_data",  od[k],           32'd0);
      chk("rst_out_count", ocx[k],          32'd0);
      chk("rst_out_ovf",   {31'b0, ovf[k]}, 32'd0);
    end

    // 1.0 + 2.0 + 3.0
    send(0, 32'h3F800000, 1'b0);
    send(0, 32'h40000000, 1'b0);
    send(0, 32'h40400000, 1'b1);
    chk("t1_busy_in_ready", {31'b0, ir[0]}, 32'd0);
    wait_out(0, lat);
    chk("t1_latency", lat, 32'd1);
    chk("t1_data",  od[0], 32'h40C00000);
    chk("t1_count", ocx[0], 32'd3);
    chk("t1_ovf",   {31'b0, ovf[0]}, 32'd0);
    @(negedge clk);
    chk("t1_valid_drop", {31'b0, ov[0]}, 32'd0);
    chk("t1_restart",    {31'b0, ir[0]}, 32'd1);

    // single element returns the operand bit-exact
    send(0, 32'hBF800000, 1'b1);
    wait_out(0, lat);
    chk("t2_data",  od[0], 32'hBF800000);
    chk("t2_count", ocx[0], 32'd1);
    @(negedge clk);

    // backpressure holds outputs stable
    ordy[0] = 1'b0;
    send(0, 32'h3F800000, 1'b0);
    send(0, 32'hBF800000, 1'b1);
    wait_out(0, lat);
    repeat (5) begin
      chk("t3_hold_valid", {31'b0, ov[0]}, 32'd1);
      chk("t3_hold_data",  od[0], 32'h00000000);
      chk("t3_hold_count", ocx[0], 32'd2);
      chk("t3_hold_ready", {31'b0, ir[0]}, 32'd0);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("t3_release_valid", {31'b0, ov[0]}, 32'd0);
    chk("t3_release_ready", {31'b0, ir[0]}, 32'd1);

    // reset during ADD of the second element discards the partial sum
    send(0, 32'h3F800000, 1'b0);
    send(0, 32'h40000000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_in_ready",  {31'b0, ir[0]}, 32'd1);
    chk("t5_out_valid", {31'b0, ov[0]}, 32'd0);
    send(0, 32'h40000000, 1'b1);
    wait_out(0, lat);
    chk("t5_data",  od[0], 32'h40000000);
    chk("t5_count", ocx[0], 32'd1);
    @(negedge clk);

    // MAX_LEN=4 forced termination
    for (int i = 0; i < 4; i++) send(1, 32'h3F800000, 1'b0);
    wait_out(1, lat);
    chk("t4_data",  od[1], 32'h40800000);
    chk("t4_count", ocx[1], 32'd4);
    chk("t4_ovf",   {31'b0, ovf[1]}, 32'd1);
    @(negedge clk);
    send(1, 32'h3F800000, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("t4_pending_no_out", {31'b0, ov[1]}, 32'd0);
    end
    send(1, 32'h3F800000, 1'b0);
    send(1, 32'h3F800000, 1'b0);
    send(1, 32'h3F800000, 1'b1);
    wait_out(1, lat);
    chk("t4b_data",  od[1], 32'h40800000);
    chk("t4b_count", ocx[1], 32'd4);
    chk("t4b_ovf",   {31'b0, ovf[1]}, 32'd0);
    @(negedge clk);

    // ADD_LATENCY=3 with in_valid toggling
    send(2, 32'h3F800000, 1'b0);
    t_a = cyc;
    @(negedge clk);
    send(2, 32'h40000000, 1'b0);
    chk("t6_spacing1", cyc - t_a, 32'd4);
    t_a = cyc;
    @(negedge clk);
    send(2, 32'h40400000, 1'b1);
    chk("t6_spacing2", cyc - t_a, 32'd4);
    wait_out(2, lat);
    chk("t6_latency", lat, 32'd3);
    chk("t6_data",  od[2], 32'h40C00000);
    chk("t6_count", ocx[2], 32'd3);
    chk("t6_ovf",   {31'b0, ovf[2]}, 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
